// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: op encodings, FSM states, captured-request struct and size
// decode helpers shared by the load/store unit and its alignment datapath.
package mem_lsu_pkg;

  typedef enum logic [2:0] {
    LNONE = 3'd0, LB = 3'd1, LH = 3'd2, LW = 3'd3,
    LBU   = 3'd4, LHU = 3'd5, LWU = 3'd6, LD = 3'd7
  } ld_op_e;

  // Store codes 5..7 are unused and decode as illegal.
  typedef enum logic [2:0] {
    SNONE = 3'd0, SB = 3'd1, SH = 3'd2, SW = 3'd3, SD = 3'd4
  } st_op_e;

  typedef enum logic [1:0] {IDLE, RESP, SECOND, MERGE} lsu_state_e;

  // Request attributes that must survive until the response is presented.
  typedef struct packed {
    logic [2:0] op;     // load op, drives the alignment/extension path
    logic       load;   // 1: load, 0: store ack
    logic       fault;  // response carries a fault, no RAM data
  } req_cap_t;

  localparam int SZ_B = 1;
  localparam int SZ_H = 2;
  localparam int SZ_W = 4;
  localparam int SZ_D = 8;

  function automatic int ld_size(input logic [2:0] op);
    case (op)
      LB, LBU: return SZ_B;
      LH, LHU: return SZ_H;
      LW, LWU: return SZ_W;
      LD:      return SZ_D;
      default: return 0;
    endcase
  endfunction

  function automatic int st_size(input logic [2:0] op);
    case (op)
      SB:      return SZ_B;
      SH:      return SZ_H;
      SW:      return SZ_W;
      SD:      return SZ_D;
      default: return 0;
    endcase
  endfunction

  function automatic logic ld_signed(input logic [2:0] op);
    return (op == LB) || (op == LH) || (op == LW);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_align: combinational load formatter. Shifts the 2*NB-byte raw window
// (high word = second beat, low word = first beat) right by the byte offset
// and sign/zero-extends to XLEN according to the load op.
//   i_op   load op (ld_op_e encoding)
//   i_off  byte offset within the first word
//   i_raw  {beat1, beat0} raw RAM data
//   o_data extended XLEN result
module mem_align
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int LG = $clog2(NB)
) (
  input  logic [2:0]        i_op,
  input  logic [LG-1:0]     i_off,
  input  logic [2*XLEN-1:0] i_raw,
  output logic [XLEN-1:0]   o_data
);

  logic [2*XLEN-1:0] w_sh;
  int                w_nbits;
  logic              w_sgn;

  always_comb begin
    w_sh    = i_raw >> {i_off, 3'b000};
    w_nbits = 8 * ld_size(i_op);
    if (w_nbits > XLEN) w_nbits = XLEN;
    w_sgn = 1'b0;
    if (ld_signed(i_op) && w_nbits > 0) w_sgn = w_sh[w_nbits-1];
    o_data = '0;
    for (int i = 0; i < XLEN; i++) o_data[i] = (i < w_nbits) ? w_sh[i] : w_sgn;
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between execute and a word-wide synchronous RAM
// (read latency 1). Aligned accesses take one RAM beat; word-crossing
// accesses take two beats and are merged, or fault when ALLOW_MISAL=0.
// One response per accepted request, in order.
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_read_op/req_write_op       load / store op
//   req_addr, req_wdata            byte address, right-justified store data
//   resp_valid/rdata/fault         one-cycle response pulse
//   mem_addr/re/we/wdata/rdata     RAM port (word address, byte enables)
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int ALLOW_MISAL = 1,
  localparam int NB   = XLEN / 8,
  localparam int LG   = $clog2(NB),
  localparam int WA_W = ADDR_W - LG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_read_op,
  input  logic [2:0]        req_write_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  output logic [WA_W-1:0]   mem_addr,
  output logic              mem_re,
  output logic [NB-1:0]     mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_e r_state, w_nxt;
  req_cap_t   r_cap;
  logic [LG-1:0]   r_off;
  logic [WA_W-1:0] r_addr1;
  logic [NB-1:0]   r_we1;
  logic [XLEN-1:0] r_wd1, r_hold;

  logic              w_accept, w_rd_en, w_wr_en, w_illegal, w_misal, w_cross, w_fault;
  logic [LG-1:0]     w_off;
  logic [WA_W-1:0]   w_waddr;
  int                w_sz;
  logic [2*NB-1:0]   w_mask2;
  logic [2*XLEN-1:0] w_wd2, w_raw;
  logic [XLEN-1:0]   w_ld_data;

  assign req_ready = !reset && (r_state != SECOND);
  assign w_accept  = req_valid && req_ready;
  assign w_off     = req_addr[LG-1:0];
  assign w_waddr   = req_addr[ADDR_W-1:LG];
  assign w_rd_en   = (req_read_op != LNONE);
  assign w_wr_en   = (req_write_op != SNONE);

  // Request decode. The 2*NB-byte mask / shifted data cover both beats:
  // low half goes out with beat0, high half is parked for beat1.
  always_comb begin
    w_sz      = w_rd_en ? ld_size(req_read_op) : st_size(req_write_op);
    w_illegal = (w_rd_en && w_wr_en) || (req_write_op > SD) ||
                ((XLEN == 32) && (req_read_op == LD || req_read_op == LWU ||
                                  req_write_op == SD));
    w_misal   = (w_sz > 0) && ((int'(w_off) & (w_sz - 1)) != 0);
    w_cross   = (int'(w_off) + w_sz) > NB;
    w_fault   = w_illegal || (w_misal && (ALLOW_MISAL == 0));
    for (int b = 0; b < 2*NB; b++)
      w_mask2[b] = (b >= int'(w_off)) && (b < int'(w_off) + w_sz);
    w_wd2 = {{XLEN{1'b0}}, req_wdata} << {w_off, 3'b000};
  end

  // RAM port: SECOND replays the parked beat1; otherwise an accepted,
  // non-faulting request issues beat0 (also while RESP/MERGE present data).
  always_comb begin
    mem_addr  = w_waddr;
    mem_re    = 1'b0;
    mem_we    = '0;
    mem_wdata = w_wd2[XLEN-1:0];
    if (r_state == SECOND) begin
      mem_addr  = r_addr1;
      mem_re    = r_cap.load;
      mem_we    = r_we1;
      mem_wdata = r_wd1;
    end else if (w_accept && !w_fault) begin
      mem_re = w_rd_en;
      mem_we = w_wr_en ? w_mask2[NB-1:0] : '0;
    end
    if (reset) begin
      mem_re = 1'b0;
      mem_we = '0;
    end
  end

  always_comb begin
    w_nxt = IDLE;
    if (r_state == SECOND)             w_nxt = MERGE;
    else if (w_accept) begin
      if (w_fault)                     w_nxt = RESP;
      else if (!w_rd_en && !w_wr_en)   w_nxt = IDLE;  // NONE/NONE: no response
      else if (w_cross)                w_nxt = SECOND;
      else                             w_nxt = RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (r_state == SECOND) r_hold <= mem_rdata;  // beat0 data arrives now
    if (w_accept) begin
      r_cap.op    <= req_read_op;
      r_cap.load  <= w_rd_en;
      r_cap.fault <= w_fault;
      r_off       <= w_off;
      r_addr1     <= w_waddr + WA_W'(1);         // wraps at top of space
      r_we1       <= (w_wr_en && !w_fault) ? w_mask2[2*NB-1:NB] : '0;
      r_wd1       <= w_wd2[2*XLEN-1:XLEN];
    end
  end

  assign w_raw = (r_state == MERGE) ? {mem_rdata, r_hold} : {{XLEN{1'b0}}, mem_rdata};

  mem_align #(.XLEN(XLEN)) u_align (
    .i_op  (r_cap.op),
    .i_off (r_off),
    .i_raw (w_raw),
    .o_data(w_ld_data)
  );

  assign resp_valid = !reset && (r_state == RESP || r_state == MERGE);
  assign resp_fault = resp_valid && r_cap.fault;
  assign resp_rdata = (resp_valid && r_cap.load && !r_cap.fault) ? w_ld_data : '0;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu. Three instances: A (XLEN=32,
// misaligned split), B (XLEN=32, misaligned faults), C (XLEN=64). Stimulus
// pushes expected responses; a negedge monitor pops and compares. RAM models
// log every access for later comparison against hand-computed beats.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] data;
    logic        fault;
    int          due;
    logic [1:0]  dut;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        re;
    logic [7:0]  we;
    logic [63:0] wd;
  } mem_ev_t;

  exp_t    exp_q[$];
  mem_ev_t log_q[$];

  // shared request bus, steered to one instance by sel
  logic        t_valid = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [2:0]  t_rd = 3'd0, t_wr = 3'd0;
  logic [31:0] t_addr = '0;
  logic [63:0] t_wdata = '0;

  logic a_ready, a_rv, a_rf, a_re;
  logic [31:0] a_rdata, a_wdata, a_mrdata;
  logic [29:0] a_maddr;
  logic [3:0]  a_we;
  logic b_ready, b_rv, b_rf, b_re;
  logic [31:0] b_rdata, b_wdata, b_mrdata;
  logic [29:0] b_maddr;
  logic [3:0]  b_we;
  logic c_ready, c_rv, c_rf, c_re;
  logic [63:0] c_rdata, c_wdata, c_mrdata;
  logic [28:0] c_maddr;
  logic [7:0]  c_we;

  mem_lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISAL(1)) u_a (
    .clk(clk), .reset(reset), .req_valid(t_valid && (sel == 2'd0)), .req_ready(a_ready),
    .req_read_op(t_rd), .req_write_op(t_wr), .req_addr(t_addr), .req_wdata(t_wdata[31:0]),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_fault(a_rf),
    .mem_addr(a_maddr), .mem_re(a_re), .mem_we(a_we), .mem_wdata(a_wdata), .mem_rdata(a_mrdata));

  mem_lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISAL(0)) u_b (
    .clk(clk), .reset(reset), .req_valid(t_valid && (sel == 2'd1)), .req_ready(b_ready),
    .req_read_op(t_rd), .req_write_op(t_wr), .req_addr(t_addr), .req_wdata(t_wdata[31:0]),
    .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_fault(b_rf),
    .mem_addr(b_maddr), .mem_re(b_re), .mem_we(b_we), .mem_wdata(b_wdata), .mem_rdata(b_mrdata));

  mem_lsu #(.XLEN(64), .ADDR_W(32), .ALLOW_MISAL(1)) u_c (
    .clk(clk), .reset(reset), .req_valid(t_valid && (sel == 2'd2)), .req_ready(c_ready),
    .req_read_op(t_rd), .req_write_op(t_wr), .req_addr(t_addr), .req_wdata(t_wdata),
    .resp_valid(c_rv), .resp_rdata(c_rdata), .resp_fault(c_rf),
    .mem_addr(c_maddr), .mem_re(c_re), .mem_we(c_we), .mem_wdata(c_wdata), .mem_rdata(c_mrdata));

  // RAM models (16 words each), read latency 1, byte write enables
  logic [31:0] ram_a[16];
  logic [31:0] ram_b[16];
  logic [63:0] ram_c[16];

  always @(posedge clk) begin
    if (a_re) a_mrdata <= ram_a[a_maddr[3:0]];
    for (int b = 0; b < 4; b++) if (a_we[b]) ram_a[a_maddr[3:0]][8*b +: 8] <= a_wdata[8*b +: 8];
    if (a_re || (|a_we)) log_q.push_back('{addr: 32'(a_maddr), re: a_re, we: {4'b0, a_we}, wd: 64'(a_wdata)});
  end
  always @(posedge clk) begin
    if (b_re) b_mrdata <= ram_b[b_maddr[3:0]];
    for (int b = 0; b < 4; b++) if (b_we[b]) ram_b[b_maddr[3:0]][8*b +: 8] <= b_wdata[8*b +: 8];
    if (b_re || (|b_we)) log_q.push_back('{addr: 32'(b_maddr), re: b_re, we: {4'b0, b_we}, wd: 64'(b_wdata)});
  end
  always @(posedge clk) begin
    if (c_re) c_mrdata <= ram_c[c_maddr[3:0]];
    for (int b = 0; b < 8; b++) if (c_we[b]) ram_c[c_maddr[3:0]][8*b +: 8] <= c_wdata[8*b +: 8];
    if (c_re || (|c_we)) log_q.push_back('{addr: 32'(c_maddr), re: c_re, we: c_we, wd: c_wdata});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic check_resp(input logic [1:0] d, input logic [63:0] data, input logic f);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL unexpected_resp dut=%0d data=%h fault=%b required no response", d, data, f);
    end else begin
      e = exp_q.pop_front();
      chk("resp_dut",   64'(d),   64'(e.dut));
      chk("resp_data",  data,     e.data);
      chk("resp_fault", 64'(f),   64'(e.fault));
      chk("resp_cycle", 64'(cyc), 64'(e.due));
    end
  endtask

  // monitor: decoupled from stimulus
  always @(negedge clk) begin
    if (a_rv) check_resp(2'd0, 64'(a_rdata), a_rf);
    if (b_rv) check_resp(2'd1, 64'(b_rdata), b_rf);
    if (c_rv) check_resp(2'd2, c_rdata, c_rf);
  end

  function automatic logic cur_ready();
    case (sel)
      2'd0:    return a_ready;
      2'd1:    return b_ready;
      default: return c_ready;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] d, input logic [2:0] rd, input logic [2:0] wr,
                       input logic [31:0] addr, input logic [63:0] wd,
                       input logic [63:0] edata, input logic ef, input int lat, input bit push);
    bit done = 1'b0;
    sel = d; t_rd = rd; t_wr = wr; t_addr = addr; t_wdata = wd; t_valid = 1'b1;
    for (int n = 0; n < 16 && !done; n++) begin
      #1;
      if (cur_ready()) begin
        if (push) exp_q.push_back('{data: edata, fault: ef, due: cyc + lat, dut: d});
        done = 1'b1;
      end
      @(negedge clk);
    end
    t_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout dut=%0d addr=%h ready never seen", d, addr);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_mem(input string nm, input logic [31:0] addr, input logic re,
                         input logic [7:0] we, input logic [63:0] wd);
    mem_ev_t     e;
    logic [63:0] m;
    if (log_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s no RAM access seen, required word=%h", nm, addr);
    end else begin
      e = log_q.pop_front();
      m = '0;
      for (int b = 0; b < 8; b++) if (we[b]) m[8*b +: 8] = 8'hFF;
      chk({nm, "_addr"}, 64'(e.addr), 64'(addr));
      chk({nm, "_re"},   64'(e.re),   64'(re));
      chk({nm, "_we"},   64'(e.we),   64'(we));
      chk({nm, "_wd"},   e.wd & m,    wd & m);
    end
  endtask

  task automatic chk_mem_none(input string nm);
    chk(nm, 64'(log_q.size()), 64'd0);
    log_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin ram_a[i] = '0; ram_b[i] = '0; ram_c[i] = '0; end
    ram_a[4] = 32'h89ABCDEF;
    ram_b[1] = 32'h12345678;
    ram_c[0] = 64'h8877665544332211;
    ram_c[1] = 64'hF1E2D3C4B5A69788;

    // reset with a request held present
    sel = 2'd0; t_rd = LW; t_addr = 32'h10; t_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready_a", 64'(a_ready), 64'd0);
    chk("rst_ready_c", 64'(c_ready), 64'd0);
    chk("rst_rv_a",    64'(a_rv),    64'd0);
    chk("rst_fault_a", 64'(a_rf),    64'd0);
    chk("rst_re_a",    64'(a_re),    64'd0);
    chk("rst_we_a",    64'(a_we),    64'd0);
    chk_mem_none("rst_no_mem");
    @(negedge clk);
    t_valid = 1'b0; t_rd = LNONE; reset = 1'b0;
    #1;
    chk("ready_after_rst", 64'(a_ready), 64'd1);
    @(negedge clk);

    // A: aligned loads back-to-back on word 4
    issue(0, LW,  SNONE, 32'h10, 0, 64'h89ABCDEF, 0, 1, 1);
    issue(0, LB,  SNONE, 32'h13, 0, 64'hFFFFFF89, 0, 1, 1);
    issue(0, LBU, SNONE, 32'h13, 0, 64'h00000089, 0, 1, 1);
    issue(0, LH,  SNONE, 32'h12, 0, 64'hFFFF89AB, 0, 1, 1);
    issue(0, LHU, SNONE, 32'h10, 0, 64'h0000CDEF, 0, 1, 1);
    drain();
    for (int i = 0; i < 5; i++) chk_mem("a_ld_w4", 32'd4, 1, 8'h0, 0);
    chk_mem_none("a_ld_extra");

    // A: split load across words 3/4, then non-crossing misaligned half
    ram_a[3] = 32'h44332211;
    ram_a[4] = 32'h88776655;
    issue(0, LW, SNONE, 32'h0E, 0, 64'h66554433, 0, 2, 1);
    chk("ready_in_second", 64'(a_ready), 64'd0);
    issue(0, LH, SNONE, 32'h11, 0, 64'h00007766, 0, 1, 1);
    drain();
    chk_mem("a_split_b0", 32'd3, 1, 8'h0, 0);
    chk_mem("a_split_b1", 32'd4, 1, 8'h0, 0);
    chk_mem("a_misal_h",  32'd4, 1, 8'h0, 0);
    chk_mem_none("a_split_extra");

    // A: split store, read it back, byte store at offset 1
    issue(0, LNONE, SW, 32'h07, 64'hAABBCCDD, 0, 0, 2, 1);
    issue(0, LW, SNONE, 32'h07, 0, 64'hAABBCCDD, 0, 2, 1);
    issue(0, LNONE, SB, 32'h21, 64'h5A, 0, 0, 1, 1);
    issue(0, LBU, SNONE, 32'h21, 0, 64'h5A, 0, 1, 1);
    drain();
    chk_mem("a_st_b0", 32'd1, 0, 8'b1000, 64'hDD000000);
    chk_mem("a_st_b1", 32'd2, 0, 8'b0111, 64'h00AABBCC);
    chk_mem("a_rb_b0", 32'd1, 1, 8'h0, 0);
    chk_mem("a_rb_b1", 32'd2, 1, 8'h0, 0);
    chk_mem("a_sb",    32'd8, 0, 8'b0010, 64'h5A00);
    chk_mem("a_lbu",   32'd8, 1, 8'h0, 0);
    chk_mem_none("a_st_extra");
    chk("ram_a1", 64'(ram_a[1]), 64'hDD000000);
    chk("ram_a2", 64'(ram_a[2]), 64'h00AABBCC);

    // A: illegal ops and NONE/NONE
    issue(0, LD,    SNONE, 32'h0, 0, 0, 1, 1, 1);
    issue(0, LW,    SW,    32'h0, 0, 0, 1, 1, 1);
    issue(0, LNONE, SD,    32'h0, 0, 0, 1, 1, 1);
    issue(0, LNONE, SNONE, 32'h0, 0, 0, 0, 1, 0);
    drain();
    chk_mem_none("a_fault_no_mem");

    // B: misaligned faults when splitting is disabled
    issue(1, LH, SNONE, 32'h01, 0, 0, 1, 1, 1);
    issue(1, LD, SNONE, 32'h00, 0, 0, 1, 1, 1);
    issue(1, LW, SNONE, 32'h04, 0, 64'h12345678, 0, 1, 1);
    issue(1, LH, SNONE, 32'h06, 0, 64'h00001234, 0, 1, 1);
    drain();
    chk_mem("b_lw", 32'd1, 1, 8'h0, 0);
    chk_mem("b_lh", 32'd1, 1, 8'h0, 0);
    chk_mem_none("b_extra");

    // C: XLEN=64 back-to-back, then 64-bit splits
    issue(2, LD,  SNONE, 32'h0, 0, 64'h8877665544332211, 0, 1, 1);
    issue(2, LW,  SNONE, 32'hC, 0, 64'hFFFFFFFFF1E2D3C4, 0, 1, 1);
    issue(2, LWU, SNONE, 32'hC, 0, 64'h00000000F1E2D3C4, 0, 1, 1);
    issue(2, LD,  SNONE, 32'h4, 0, 64'hB5A6978888776655, 0, 2, 1);
    issue(2, LH,  SNONE, 32'h7, 0, 64'hFFFFFFFFFFFF8888, 0, 2, 1);
    drain();
    chk_mem("c_ld",    32'd0, 1, 8'h0, 0);
    chk_mem("c_lw",    32'd1, 1, 8'h0, 0);
    chk_mem("c_lwu",   32'd1, 1, 8'h0, 0);
    chk_mem("c_sp0",   32'd0, 1, 8'h0, 0);
    chk_mem("c_sp1",   32'd1, 1, 8'h0, 0);
    chk_mem("c_sph0",  32'd0, 1, 8'h0, 0);
    chk_mem("c_sph1",  32'd1, 1, 8'h0, 0);
    chk_mem_none("c_extra");

    // C: reset during SECOND drops the pending beat and response
    issue(2, LD, SNONE, 32'h4, 0, 0, 0, 2, 0);
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", 64'(c_ready), 64'd0);
    chk("rst_mid_re",    64'(c_re),    64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_ready_after", 64'(c_ready), 64'd1);
    repeat (3) @(negedge clk);
    drain();
    chk_mem("c_rst_b0", 32'd0, 1, 8'h0, 0);
    chk_mem_none("c_rst_no_b1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
